// File: rtl/regfile_ctrl_pkg.sv
// Shared constants and types for the register-file write-back controller.
// The request enum tags which write-back stage owned the most recent grant.
package regfile_ctrl_pkg;

   localparam int DATA_W = 8;
   localparam int ADDR_W = 2;
   localparam int NREG   = 4;

   typedef enum logic {
      REQ_ALU = 1'b0,
      REQ_MEM = 1'b1
   } wb_req_e;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-way round-robin arbiter between the ALU and memory write-back stages.
// Grants depend only on the valids and the remembered last winner, never on ready.
module wb_rr_arbiter
   import regfile_ctrl_pkg::*;
(
   input  logic clk,
   input  logic rst_n,
   input  logic alu_valid_i,
   input  logic mem_valid_i,
   output logic alu_grant_o,
   output logic mem_grant_o
);

   wb_req_e lastGrant_q, lastGrant_d;

   // A tie goes to whichever requester did not win the previous transfer.
   always_comb begin
      alu_grant_o = alu_valid_i && (!mem_valid_i || (lastGrant_q == REQ_MEM));
      mem_grant_o = mem_valid_i && !alu_grant_o;
      lastGrant_d = lastGrant_q;
      if (alu_grant_o) begin
         lastGrant_d = REQ_ALU;
      end else if (mem_grant_o) begin
         lastGrant_d = REQ_MEM;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lastGrant_q <= REQ_MEM;
      end else begin
         lastGrant_q <= lastGrant_d;
      end
   end

endmodule

// File: rtl/regfile_wb_ctrl.sv
// Write-back controller: arbitrates the single register-file write port and
// tracks pending writes per register to stall decode on read-after-write hazards.
module regfile_wb_ctrl #(
   parameter int DATA_W = regfile_ctrl_pkg::DATA_W,
   parameter int ADDR_W = regfile_ctrl_pkg::ADDR_W,
   parameter int NREG   = regfile_ctrl_pkg::NREG
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid_i,
   input  logic [ADDR_W-1:0] alu_rd_i,
   input  logic [DATA_W-1:0] alu_data_i,
   output logic              alu_ready_o,
   input  logic              mem_valid_i,
   input  logic [ADDR_W-1:0] mem_rd_i,
   input  logic [DATA_W-1:0] mem_data_i,
   output logic              mem_ready_o,
   input  logic              issue_valid_i,
   input  logic [ADDR_W-1:0] issue_rd_i,
   input  logic [ADDR_W-1:0] rs_i,
   input  logic [ADDR_W-1:0] rt_i,
   output logic              stall_o,
   output logic              rf_we_o,
   output logic [ADDR_W-1:0] rf_rd_o,
   output logic [DATA_W-1:0] rf_wdata_o,
   output logic [NREG-1:0]   busy_o,
   output logic              err_o
);

   logic              aluGrant, memGrant;
   logic              rfWe_q, rfWe_d;
   logic [ADDR_W-1:0] rfRd_q, rfRd_d;
   logic [DATA_W-1:0] rfWdata_q, rfWdata_d;
   logic [1:0]        cnt_q [NREG];
   logic [1:0]        cnt_d [NREG];
   logic              err_q, err_d;
   logic [NREG-1:0]   busy;
   logic              issueAccept;

   wb_rr_arbiter u_arb (
      .clk         (clk),
      .rst_n       (rst_n),
      .alu_valid_i (alu_valid_i),
      .mem_valid_i (mem_valid_i),
      .alu_grant_o (aluGrant),
      .mem_grant_o (memGrant)
   );

   assign alu_ready_o = aluGrant;
   assign mem_ready_o = memGrant;

   always_comb begin
      rfWe_d    = aluGrant || memGrant;
      rfRd_d    = rfRd_q;
      rfWdata_d = rfWdata_q;
      if (aluGrant) begin
         rfRd_d    = alu_rd_i;
         rfWdata_d = alu_data_i;
      end else if (memGrant) begin
         rfRd_d    = mem_rd_i;
         rfWdata_d = mem_data_i;
      end
   end

   always_comb begin
      busy = '0;
      for (int r = 0; r < NREG; r++) begin
         busy[r] = (cnt_q[r] != 2'd0);
      end
   end

   assign stall_o     = issue_valid_i &&
                        (busy[rs_i] || busy[rt_i] || (cnt_q[issue_rd_i] == 2'd3));
   assign issueAccept = issue_valid_i && !stall_o;

   // The commit in flight retires one pending write as the register file
   // absorbs it; a commit to an idle register is an underflow, not a wrap.
   always_comb begin
      err_d = err_q;
      for (int r = 0; r < NREG; r++) begin
         cnt_d[r] = cnt_q[r];
         if (rfWe_q && (rfRd_q == ADDR_W'(r)) && (cnt_q[r] == 2'd0)) begin
            err_d = 1'b1;
         end
         if (issueAccept && (issue_rd_i == ADDR_W'(r)) &&
             !(rfWe_q && (rfRd_q == ADDR_W'(r)))) begin
            cnt_d[r] = cnt_q[r] + 2'd1;
         end else if (rfWe_q && (rfRd_q == ADDR_W'(r)) &&
                      !(issueAccept && (issue_rd_i == ADDR_W'(r))) &&
                      (cnt_q[r] != 2'd0)) begin
            cnt_d[r] = cnt_q[r] - 2'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rfWe_q    <= 1'b0;
         rfRd_q    <= '0;
         rfWdata_q <= '0;
         err_q     <= 1'b0;
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= 2'd0;
         end
      end else begin
         rfWe_q    <= rfWe_d;
         rfRd_q    <= rfRd_d;
         rfWdata_q <= rfWdata_d;
         err_q     <= err_d;
         for (int r = 0; r < NREG; r++) begin
            cnt_q[r] <= cnt_d[r];
         end
      end
   end

   assign rf_we_o    = rfWe_q;
   assign rf_rd_o    = rfRd_q;
   assign rf_wdata_o = rfWdata_q;
   assign busy_o     = busy;
   assign err_o      = err_q;

endmodule

// File: tb/tb_regfile_wb_ctrl.sv
// Self-checking bench for regfile_wb_ctrl: directed scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_regfile_wb_ctrl;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       alu_valid, mem_valid, issue_valid;
   logic [1:0] alu_rd, mem_rd, issue_rd, rs, rt;
   logic [7:0] alu_data, mem_data;
   logic       alu_ready, mem_ready, stall, rf_we, err;
   logic [1:0] rf_rd;
   logic [7:0] rf_wdata;
   logic [3:0] busy;

   int passCount = 0;
   int checkCount = 0;
   int failCount = 0;

   // Model state: pending counts, sticky error, who won last, write-stage view.
   int         mCnt [4];
   logic       mErr;
   logic       mLastMem;
   logic       mWe;
   logic [1:0] mRd;
   logic [7:0] mWdata;
   logic       mAluXfer, mMemXfer;

   always #5 clk = ~clk;

   regfile_wb_ctrl dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .alu_valid_i   (alu_valid),
      .alu_rd_i      (alu_rd),
      .alu_data_i    (alu_data),
      .alu_ready_o   (alu_ready),
      .mem_valid_i   (mem_valid),
      .mem_rd_i      (mem_rd),
      .mem_data_i    (mem_data),
      .mem_ready_o   (mem_ready),
      .issue_valid_i (issue_valid),
      .issue_rd_i    (issue_rd),
      .rs_i          (rs),
      .rt_i          (rt),
      .stall_o       (stall),
      .rf_we_o       (rf_we),
      .rf_rd_o       (rf_rd),
      .rf_wdata_o    (rf_wdata),
      .busy_o        (busy),
      .err_o         (err)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
      end
   endtask

   task automatic applyStimulus(input logic av, input logic [1:0] ard, input logic [7:0] adat,
                                input logic mv, input logic [1:0] mrd, input logic [7:0] mdat,
                                input logic iv, input logic [1:0] ird,
                                input logic [1:0] srs, input logic [1:0] srt);
      alu_valid   = av;
      alu_rd      = ard;
      alu_data    = adat;
      mem_valid   = mv;
      mem_rd      = mrd;
      mem_data    = mdat;
      issue_valid = iv;
      issue_rd    = ird;
      rs          = srs;
      rt          = srt;
   endtask

   task automatic idle();
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
   endtask

   task automatic resetModel();
      for (int r = 0; r < 4; r++) mCnt[r] = 0;
      mErr     = 1'b0;
      mLastMem = 1'b1;
      mWe      = 1'b0;
      mRd      = 2'd0;
      mWdata   = 8'h00;
      mAluXfer = 1'b0;
      mMemXfer = 1'b0;
   endtask

   // One clock cycle: compare everything at the falling edge, then advance the model.
   task automatic stepCycle();
      logic       expAlu, expMem, expStall, nErr;
      logic [3:0] expBusy;
      int         nCnt [4];
      bit         inc, dec;
      @(negedge clk);
      expAlu   = alu_valid && (!mem_valid || mLastMem);
      expMem   = mem_valid && (!alu_valid || !mLastMem);
      expStall = issue_valid && (mCnt[rs] != 0 || mCnt[rt] != 0 || mCnt[issue_rd] == 3);
      for (int r = 0; r < 4; r++) expBusy[r] = (mCnt[r] != 0);
      checkOutput("alu_ready", 32'(alu_ready), 32'(expAlu));
      checkOutput("mem_ready", 32'(mem_ready), 32'(expMem));
      checkOutput("stall", 32'(stall), 32'(expStall));
      checkOutput("rf_we", 32'(rf_we), 32'(mWe));
      checkOutput("rf_rd", 32'(rf_rd), 32'(mRd));
      checkOutput("rf_wdata", 32'(rf_wdata), 32'(mWdata));
      checkOutput("busy", 32'(busy), 32'(expBusy));
      checkOutput("err", 32'(err), 32'(mErr));
      nErr = mErr;
      for (int r = 0; r < 4; r++) begin
         inc = issue_valid && !expStall && (int'(issue_rd) == r);
         dec = mWe && (int'(mRd) == r);
         nCnt[r] = mCnt[r];
         if (dec && mCnt[r] == 0) nErr = 1'b1;
         if (inc && !dec) nCnt[r] = mCnt[r] + 1;
         else if (dec && !inc && mCnt[r] > 0) nCnt[r] = mCnt[r] - 1;
      end
      @(posedge clk);
      mCnt     = nCnt;
      mErr     = nErr;
      mAluXfer = expAlu;
      mMemXfer = expMem;
      mWe      = expAlu || expMem;
      if (expAlu) begin
         mRd = alu_rd; mWdata = alu_data; mLastMem = 1'b0;
      end else if (expMem) begin
         mRd = mem_rd; mWdata = mem_data; mLastMem = 1'b1;
      end
      #1;
   endtask

   logic [1:0] tieRd   [4] = '{2'd0, 2'd1, 2'd2, 2'd3};
   logic [7:0] tieData [4] = '{8'hA0, 8'hB1, 8'hA2, 8'hB3};

   initial begin
      logic       av, mv;
      logic [1:0] ard, mrd;
      logic [7:0] adat, mdat;

      resetModel();
      idle();
      repeat (2) @(posedge clk);
      #1;
      checkOutput("reset_rf_we", 32'(rf_we), 32'd0);
      checkOutput("reset_rf_rd", 32'(rf_rd), 32'd0);
      checkOutput("reset_rf_wdata", 32'(rf_wdata), 32'd0);
      checkOutput("reset_busy", 32'(busy), 32'd0);
      checkOutput("reset_err", 32'(err), 32'd0);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Reset landing while a write sits in the write stage.
      applyStimulus(1'b1, 2'd0, 8'h77, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      #1 checkOutput("alu_only_ready", 32'(alu_ready), 32'd1);
      checkOutput("alu_only_mem_ready", 32'(mem_ready), 32'd0);
      stepCycle();
      checkOutput("pre_reset_we", 32'(rf_we), 32'd1);
      idle();
      #2 rst_n = 1'b0;
      #1;
      checkOutput("midreset_rf_we", 32'(rf_we), 32'd0);
      checkOutput("midreset_busy", 32'(busy), 32'd0);
      checkOutput("midreset_err", 32'(err), 32'd0);
      resetModel();
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Pending writes for r0 (twice), r1, r2, r3.
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1,
                       (i == 0) ? 2'd0 : 2'(i - 1), 2'd3, 2'd3);
         stepCycle();
      end

      // Contention: ALU wins the first tie after reset, then strict alternation.
      for (int k = 0; k < 4; k++) begin
         applyStimulus(1'b1, (k < 2) ? ((k == 0) ? 2'd0 : 2'd2) : ((k == 2) ? 2'd2 : 2'd0),
                       (k < 2) ? ((k == 0) ? 8'hA0 : 8'hA2) : ((k == 2) ? 8'hA2 : 8'hA4),
                       1'b1, (k < 3) ? 2'd1 : 2'd3, (k < 3) ? 8'hB1 : 8'hB3,
                       1'b0, 2'd0, 2'd0, 2'd0);
         if (k == 2) begin
            mem_rd = 2'd3; mem_data = 8'hB3;
         end
         #1 checkOutput("tie_alu_ready", 32'(alu_ready), 32'((k % 2) == 0));
         stepCycle();
         checkOutput("tie_rf_we", 32'(rf_we), 32'd1);
         checkOutput("tie_rf_rd", 32'(rf_rd), 32'(tieRd[k]));
         checkOutput("tie_rf_wdata", 32'(rf_wdata), 32'(tieData[k]));
      end
      applyStimulus(1'b1, 2'd0, 8'hA4, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      stepCycle();
      idle();
      stepCycle();
      stepCycle();
      checkOutput("tie_drained_busy", 32'(busy), 32'd0);
      checkOutput("tie_no_err", 32'(err), 32'd0);

      // Single write to r2.
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd0, 2'd0);
      stepCycle();
      checkOutput("single_busy2", 32'(busy[2]), 32'd1);
      applyStimulus(1'b1, 2'd2, 8'h5A, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      #1 checkOutput("single_ready", 32'(alu_ready), 32'd1);
      stepCycle();
      checkOutput("single_we", 32'(rf_we), 32'd1);
      checkOutput("single_rd", 32'(rf_rd), 32'd2);
      checkOutput("single_wdata", 32'(rf_wdata), 32'h5A);
      idle();
      stepCycle();
      checkOutput("single_busy_clear", 32'(busy[2]), 32'd0);
      checkOutput("single_we_low", 32'(rf_we), 32'd0);

      // RAW stall on r1 released the cycle after its commit.
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0, 2'd0);
      stepCycle();
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 2'd1);
      #1 checkOutput("raw_stall_wait", 32'(stall), 32'd1);
      stepCycle();
      alu_valid = 1'b1; alu_rd = 2'd1; alu_data = 8'h11;
      #1 checkOutput("raw_stall_xfer", 32'(stall), 32'd1);
      stepCycle();
      alu_valid = 1'b0;
      #1 checkOutput("raw_stall_commit", 32'(stall), 32'd1);
      checkOutput("raw_commit_we", 32'(rf_we), 32'd1);
      stepCycle();
      checkOutput("raw_stall_released", 32'(stall), 32'd0);
      idle();
      stepCycle();

      // Commit and issue to r3 in the same cycle.
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 2'd0);
      stepCycle();
      applyStimulus(1'b1, 2'd3, 8'h33, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      stepCycle();
      applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd0, 2'd0);
      #1 checkOutput("same_rf_rd", 32'(rf_rd), 32'd3);
      checkOutput("same_no_stall", 32'(stall), 32'd0);
      stepCycle();
      idle();
      checkOutput("same_busy3", 32'(busy[3]), 32'd1);
      stepCycle();
      checkOutput("same_busy3_hold", 32'(busy[3]), 32'd1);
      applyStimulus(1'b1, 2'd3, 8'h34, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      stepCycle();
      idle();
      stepCycle();
      checkOutput("same_busy3_clear", 32'(busy[3]), 32'd0);

      // Saturation at three pending writes to r0.
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd1, 2'd1);
         stepCycle();
      end
      #1 checkOutput("sat_stall", 32'(stall), 32'd1);
      stepCycle();
      for (int i = 0; i < 3; i++) begin
         applyStimulus(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 8'(8'hC0 + i), 1'b0, 2'd0, 2'd0, 2'd0);
         stepCycle();
      end
      idle();
      checkOutput("sat_busy_last", 32'(busy[0]), 32'd1);
      stepCycle();
      checkOutput("sat_busy_drained", 32'(busy[0]), 32'd0);

      // Underflow on r1.
      applyStimulus(1'b1, 2'd1, 8'h99, 1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
      checkOutput("uf_err_before", 32'(err), 32'd0);
      stepCycle();
      idle();
      checkOutput("uf_err_commit", 32'(err), 32'd0);
      stepCycle();
      checkOutput("uf_err_set", 32'(err), 32'd1);
      checkOutput("uf_busy1", 32'(busy[1]), 32'd0);
      stepCycle();
      stepCycle();
      checkOutput("uf_err_sticky", 32'(err), 32'd1);

      // Randomized traffic, requesters holding their request until accepted.
      av = 1'b0; mv = 1'b0; ard = 2'd0; mrd = 2'd0; adat = 8'h00; mdat = 8'h00;
      for (int i = 0; i < 400; i++) begin
         if (!av || mAluXfer) begin
            av = 1'($urandom_range(0, 1)); ard = 2'($urandom); adat = 8'($urandom);
         end
         if (!mv || mMemXfer) begin
            mv = 1'($urandom_range(0, 1)); mrd = 2'($urandom); mdat = 8'($urandom);
         end
         applyStimulus(av, ard, adat, mv, mrd, mdat, 1'($urandom_range(0, 1)),
                       2'($urandom), 2'($urandom), 2'($urandom));
         stepCycle();
      end
      idle();
      stepCycle();

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/regfile_wb_ctrl.md
# regfile_wb_ctrl

Write-back controller for the 4-entry × 8-bit processor register file. It shares the file's single write port between the ALU and memory write-back stages with round-robin arbitration and valid/ready handshakes, and drives a registered write port into the register file. It also keeps a per-register pending-write scoreboard and produces the decode-stage stall for read-after-write hazards.

## Interface
- `DATA_W`, default 8: write data width.
- `ADDR_W`, default 2: register index width.
- `NREG`, default 4: number of registers; must equal 2**`ADDR_W`.

Ports:
- `clk`  in  1  sole clock; all state updates on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU write-back request.
- `alu_rd`  in  `ADDR_W`  ALU destination register.
- `alu_data`  in  `DATA_W`  ALU result.
- `alu_ready`  out  1  ALU request accepted this cycle.
- `mem_valid`, `mem_rd`, `mem_data`, `mem_ready`: the same four signals for the memory stage.
- `issue_valid`  in  1  decode is issuing an instruction that will write `issue_rd`.
- `issue_rd`  in  `ADDR_W`  destination of the issuing instruction.
- `rs`, `rt`  in  `ADDR_W`  source registers of the decoding instruction.
- `stall`  out  1  decode must hold; the issue is not recorded.
- `rf_we`  out  1  register file write enable (registered).
- `rf_rd`  out  `ADDR_W`  register file write index (registered).
- `rf_wdata`  out  `DATA_W`  register file write data (registered).
- `busy`  out  `NREG`  per-register pending-write flag.
- `err`  out  1  sticky underflow flag: a write was accepted for a register with no pending write.

## Operation
- **Handshake**
  - A write transfers in any cycle where `x_valid && x_ready`.
  - A requester holds valid, rd and data stable until ready.
  - Ready is combinational from both valids and `last_grant`; it never depends on ready.
- **Arbitration**
  - Only one requester valid: it is granted.
  - Both valid: grant the requester not in `last_grant`.
  - `last_grant` updates only on a transfer.
  - Reset value of `last_grant` is MEM, so ALU wins the first tie.
  - At most one ready is high per cycle.
- **Write stage**
  - On a transfer, `rf_we`<=1, `rf_rd`<=winner rd, `rf_wdata`<=winner data.
  - With no transfer, `rf_we`<=0 and `rf_rd`/`rf_wdata` hold their values.
- **Scoreboard**
  - Each register has a 2-bit pending count `cnt[r]`.
  - `issue_valid && !stall` increments `cnt[issue_rd]`.
  - `rf_we==1` decrements `cnt[rf_rd]` at the same edge the register file writes.
  - Increment and decrement on the same register in the same cycle leave the count unchanged.
  - `busy[r] = (cnt[r]!=0)`.
- **Stall**
  - `stall = issue_valid && (busy[rs] || busy[rt] || cnt[issue_rd]==3)`.
  - Combinational.
- **Underflow**
  - `rf_we` with `cnt[rf_rd]==0`: the count stays 0 and `err`<=1.
  - `err` clears only on reset.

## Timing
- Reset values: `rf_we`=0, `rf_rd`=0, `rf_wdata`=0, all `cnt`=0, `busy`=0, `err`=0, `last_grant`=MEM.
- Combinational outputs settle from inputs in the same cycle: `alu_ready`=`alu_valid` and `mem_ready`=0 with ALU-only valid, and `stall`=0 with all counts 0.
- Reset is asynchronous, including mid-transfer: any accepted-but-uncommitted write is dropped, and `rf_we` goes low immediately.
- Latency for a transfer in cycle T:
  - `rf_we` is high during T+1.
  - The register file holds the data from T+2.
  - `busy` drops in T+2, if that was the last pending write.
  - A stall on that register releases in T+2.
- Sustained throughput is one write per cycle.
- With both requesters continuously valid, grants strictly alternate.

## Structure
- Package `regfile_ctrl_pkg` holds:
  - constants `DATA_W`=8, `ADDR_W`=2, `NREG`=4;
  - enum `wb_req_e` {`REQ_ALU`, `REQ_MEM`}, used for `last_grant`.
- Sub-module `wb_rr_arbiter` is the 2-way round-robin grant with `last_grant` state.
- The write stage, scoreboard and stall logic live in the top module.

## Test plan
- **Reset:** assert `rst_n`=0 mid-transfer -> `rf_we`=0 immediately; all `busy`=0; `err`=0; after release, the first tie goes to ALU.
- **Single write:** issue `rd`=2, then `alu_valid` with `rd`=2, data 0x5A -> `alu_ready`=1; next cycle `rf_we`=1, `rf_rd`=2, `rf_wdata`=0x5A; the cycle after, `busy[2]`=0.
- **Contention:** ALU and MEM both valid for 4 cycles -> grants ALU, MEM, ALU, MEM; one `rf_we` per cycle; data in matching order.
- **RAW stall:** issue `rd`=1, then `rs`=1 with `issue_valid` -> `stall`=1 until the write to r1 commits, and 0 in the cycle after `rf_we`.
- **Same-cycle events:** `cnt[3]`=1, commit to r3 and issue `rd`=3 in the same cycle -> `cnt[3]` stays 1; `busy[3]` stays 1.
- **Saturation/underflow:**
  - Three issues to r0, then a fourth issue -> `stall`=1 and the count stays 3.
  - Write to r1 with `cnt[1]`=0 -> `err`=1, sticky, and `cnt[1]` stays 0.
